// File: rtl/mem_stage_pkg.sv
// Shared widths, ALU op codes, FSM states and op-decode helpers for the memory stage.
package mem_stage_pkg;

    localparam int unsigned REG_LEN      = 32;
    localparam int unsigned REG_ADDR_LEN = 5;
    localparam int unsigned ADDR_LEN     = 32;
    localparam int unsigned ALU_LEN      = 5;
    localparam int unsigned INST_LEN     = 32;
    localparam int unsigned BEAT_CNT_W   = 2;

    typedef enum logic [ALU_LEN-1:0] {
        ALU_NOP = 5'd0,  ALU_ADD = 5'd1,  ALU_SUB = 5'd2,  ALU_AND = 5'd3,
        ALU_OR  = 5'd4,  ALU_XOR = 5'd5,  ALU_SLL = 5'd6,  ALU_SRL = 5'd7,
        ALU_SRA = 5'd8,  ALU_SLT = 5'd9,  ALU_LUI = 5'd10,
        ALU_LB  = 5'd16, ALU_LH  = 5'd17, ALU_LW  = 5'd18, ALU_LBU = 5'd19,
        ALU_LHU = 5'd20, ALU_SB  = 5'd21, ALU_SH  = 5'd22, ALU_SW  = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // One byte beat as presented to the memory controller.
    typedef struct packed {
        logic                we;
        logic [ADDR_LEN-1:0] addr;
        logic [7:0]          wbyte;
    } mc_beat_t;

    function automatic logic is_load(input logic [ALU_LEN-1:0] op);
        return op inside {ALU_LB, ALU_LH, ALU_LW, ALU_LBU, ALU_LHU};
    endfunction

    function automatic logic is_store(input logic [ALU_LEN-1:0] op);
        return op inside {ALU_SB, ALU_SH, ALU_SW};
    endfunction

    // Index of the final beat: 0 for bytes, 1 for halves, 3 for words.
    function automatic logic [BEAT_CNT_W-1:0] last_beat(input logic [ALU_LEN-1:0] op);
        logic [BEAT_CNT_W-1:0] idx;
        idx = '0;
        if (op inside {ALU_LH, ALU_LHU, ALU_SH}) idx = BEAT_CNT_W'(1);
        if (op inside {ALU_LW, ALU_SW})          idx = BEAT_CNT_W'(3);
        return idx;
    endfunction

    function automatic logic is_misaligned(input logic [ALU_LEN-1:0] op, input logic [1:0] lsb);
        logic half, word;
        half = op inside {ALU_LH, ALU_LHU, ALU_SH};
        word = op inside {ALU_LW, ALU_SW};
        return (half & lsb[0]) | (word & (lsb != 2'b00));
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Byte-wide request/grant/response port between the memory stage and the memory controller.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                mc_req;
    logic                mc_we;
    logic [ADDR_LEN-1:0] mc_addr;
    logic [7:0]          mc_wbyte;
    logic                mc_gnt;
    logic                mc_rvalid;
    logic [7:0]          mc_rbyte;

    modport master (output mc_req, mc_we, mc_addr, mc_wbyte,
                    input  mc_gnt, mc_rvalid, mc_rbyte);
    modport slave  (input  mc_req, mc_we, mc_addr, mc_wbyte,
                    output mc_gnt, mc_rvalid, mc_rbyte);
endinterface

// File: rtl/mem_stage_load_ext.sv
// Load result formatting: picks the low lanes of the assembled buffer and sign/zero-extends.
module mem_stage_load_ext
    import mem_stage_pkg::*;
(
    input  logic [REG_LEN-1:0] data,
    input  logic [ALU_LEN-1:0] op,
    output logic [REG_LEN-1:0] result_c
);

    always_comb begin
        result_c = data;
        case (op)
            ALU_LB:  result_c = {{(REG_LEN-8){data[7]}},   data[7:0]};
            ALU_LBU: result_c = {{(REG_LEN-8){1'b0}},      data[7:0]};
            ALU_LH:  result_c = {{(REG_LEN-16){data[15]}}, data[15:0]};
            ALU_LHU: result_c = {{(REG_LEN-16){1'b0}},     data[15:0]};
            default: result_c = data;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: passes non-memory ops through and serialises loads/stores into byte beats.
// Optional alignment trap selected by defining MEM_MISALIGN_CHECK_EN.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_LEN-1:0]      rd_data_i,
    input  logic [REG_ADDR_LEN-1:0] rd_addr_i,
    input  logic                    rd_enable_i,
    input  logic [ADDR_LEN-1:0]     mem_addr_i,
    input  logic [ALU_LEN-1:0]      alu_op_i,
    input  logic [INST_LEN-1:0]     mem_wdata_i,
    output logic [REG_LEN-1:0]      wb_rd_data_o,
    output logic [REG_ADDR_LEN-1:0] wb_rd_addr_o,
    output logic                    wb_rd_enable_o,
    output logic                    stall_req,
    output logic                    misalign_err,
    mem_stage_if.master             mc
);

    state_e                state_q, state_d;
    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d, cnt_nx;
    logic [REG_LEN-1:0]    ld_buf_q, ld_buf_d, ld_result;
    logic                  req_q, req_d;
    mc_beat_t              beat_q, beat_d;
    logic                  is_ld, is_st, mem_op, last, misaligned;

    assign is_ld  = is_load(alu_op_i);
    assign is_st  = is_store(alu_op_i);
    assign mem_op = is_ld | is_st;
    assign last   = (cnt_q == last_beat(alu_op_i));
    assign cnt_nx = cnt_q + BEAT_CNT_W'(1);

`ifdef MEM_MISALIGN_CHECK_EN
    assign misaligned = mem_op & is_misaligned(alu_op_i, mem_addr_i[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    mem_stage_load_ext u_load_ext (
        .data     (ld_buf_q),
        .op       (alu_op_i),
        .result_c (ld_result)
    );

    // Next-state, next-beat and combinational pipeline-side outputs.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        ld_buf_d       = ld_buf_q;
        req_d          = req_q;
        beat_d         = beat_q;
        wb_rd_data_o   = rd_data_i;
        wb_rd_addr_o   = rd_addr_i;
        wb_rd_enable_o = 1'b0;
        stall_req      = 1'b0;
        misalign_err   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!mem_op) begin
                    wb_rd_enable_o = rd_enable_i;
                end else if (misaligned) begin
                    misalign_err = 1'b1;
                end else begin
                    stall_req = 1'b1;
                    state_d   = ST_REQ;
                    cnt_d     = '0;
                    ld_buf_d  = '0;
                    req_d     = 1'b1;
                    beat_d    = '{we: is_st, addr: mem_addr_i, wbyte: mem_wdata_i[7:0]};
                end
            end
            ST_REQ: begin
                stall_req = 1'b1;
                if (mc.mc_gnt) begin
                    if (is_ld) begin
                        state_d = ST_WAIT_R;
                        req_d   = 1'b0;
                    end else if (last) begin
                        state_d = ST_DONE;
                        req_d   = 1'b0;
                    end else begin
                        cnt_d        = cnt_nx;
                        beat_d.addr  = mem_addr_i + ADDR_LEN'(cnt_nx);
                        beat_d.wbyte = mem_wdata_i[{cnt_nx, 3'b000} +: 8];
                    end
                end
            end
            ST_WAIT_R: begin
                stall_req = 1'b1;
                if (mc.mc_rvalid) begin
                    ld_buf_d[{cnt_q, 3'b000} +: 8] = mc.mc_rbyte;
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = cnt_nx;
                        req_d       = 1'b1;
                        beat_d.we   = 1'b0;
                        beat_d.addr = mem_addr_i + ADDR_LEN'(cnt_nx);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (is_ld) begin
                    wb_rd_data_o   = ld_result;
                    wb_rd_enable_o = rd_enable_i;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pipeline-side outputs read as zero while reset is held.
        if (!rst) begin
            wb_rd_data_o   = '0;
            wb_rd_addr_o   = '0;
            wb_rd_enable_o = 1'b0;
            stall_req      = 1'b0;
            misalign_err   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ld_buf_q <= '0;
            req_q    <= 1'b0;
            beat_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ld_buf_q <= ld_buf_d;
            req_q    <= req_d;
            beat_q   <= beat_d;
        end
    end

    assign mc.mc_req   = req_q;
    assign mc.mc_we    = beat_q.we;
    assign mc.mc_addr  = beat_q.addr;
    assign mc.mc_wbyte = beat_q.wbyte;

endmodule
